// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - hazard scheduler for the 5-stage MIPS pipeline
module pipeline_hazard_ctrl #(
    parameter int STALL_CYCLES = 1,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [4:0]           id_rs,
    input  logic [4:0]           id_rt,
    input  logic                 id_uses_rt,
    input  logic                 id_jump,
    input  logic [4:0]           ex_rs,
    input  logic [4:0]           ex_rt,
    input  logic                 ex_mem_read,
    input  logic [4:0]           ex_wreg,
    input  logic                 mem_reg_write,
    input  logic [4:0]           mem_wreg,
    input  logic                 mem_branch_taken,
    input  logic                 wb_reg_write,
    input  logic [4:0]           wb_wreg,
    input  logic                 mem_busy,
    output logic                 pc_write_en,
    output logic                 if_id_write_en,
    output logic                 pipe_en,
    output logic                 if_id_flush,
    output logic                 id_ex_flush,
    output logic                 ex_mem_flush,
    output logic [1:0]           fwd_a,
    output logic [1:0]           fwd_b,
    output logic [1:0]           state,
    output logic [CNT_WIDTH-1:0] stall_cnt,
    output logic [CNT_WIDTH-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        S_RUN    = 2'b00,
        S_STALL  = 2'b01,
        S_FREEZE = 2'b10
    } state_t;

    // Down-counter reload: bubbles still owed after the first one.
    localparam logic [2:0]           LP_RELOAD  = 3'(STALL_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] LP_CNT_ONE = CNT_WIDTH'(1);

    state_t               r_state;
    state_t               r_ret_state;
    state_t               w_next_state;
    state_t               w_next_ret;
    state_t               w_eff_state;
    logic [2:0]           r_dcnt;
    logic [2:0]           w_next_dcnt;
    logic [CNT_WIDTH-1:0] r_stall_cnt;
    logic [CNT_WIDTH-1:0] r_flush_cnt;
    logic                 w_lu;
    logic                 w_stall_inc;
    logic                 w_flush_inc;
    logic [1:0]           w_fwd_a;
    logic [1:0]           w_fwd_b;

    // Load-use: the load in EX writes a register the instruction in ID reads.
    always_comb begin
        w_lu = ex_mem_read && (ex_wreg != 5'd0) &&
               ((ex_wreg == id_rs) || (id_uses_rt && (ex_wreg == id_rt)));
    end

    // Forwarding selects; the younger EX_MEM result wins over WB, $0 never forwards.
    always_comb begin
        w_fwd_a = 2'b00;
        w_fwd_b = 2'b00;
        if (mem_reg_write && (mem_wreg != 5'd0) && (mem_wreg == ex_rs)) begin
            w_fwd_a = 2'b10;
        end else if (wb_reg_write && (wb_wreg != 5'd0) && (wb_wreg == ex_rs)) begin
            w_fwd_a = 2'b01;
        end
        if (mem_reg_write && (mem_wreg != 5'd0) && (mem_wreg == ex_rt)) begin
            w_fwd_b = 2'b10;
        end else if (wb_reg_write && (wb_wreg != 5'd0) && (wb_wreg == ex_rt)) begin
            w_fwd_b = 2'b01;
        end
    end

    // Next-state and control outputs; leaving FREEZE behaves as the saved state.
    always_comb begin
        w_next_state   = S_RUN;
        w_next_ret     = r_ret_state;
        w_next_dcnt    = r_dcnt;
        w_stall_inc    = 1'b0;
        w_flush_inc    = 1'b0;
        pc_write_en    = 1'b1;
        if_id_write_en = 1'b1;
        pipe_en        = 1'b1;
        if_id_flush    = 1'b0;
        id_ex_flush    = 1'b0;
        ex_mem_flush   = 1'b0;
        fwd_a          = w_fwd_a;
        fwd_b          = w_fwd_b;
        w_eff_state    = (r_state == S_FREEZE) ? r_ret_state : r_state;

        if (reset) begin
            fwd_a = 2'b00;
            fwd_b = 2'b00;
        end else if (mem_busy) begin
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
            pipe_en        = 1'b0;
            w_next_state   = S_FREEZE;
            if (r_state != S_FREEZE) begin
                w_next_ret = r_state;
            end
        end else if (mem_branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            w_next_dcnt  = 3'd0;
            w_flush_inc  = 1'b1;
        end else if (w_eff_state == S_STALL) begin
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
            id_ex_flush    = 1'b1;
            w_stall_inc    = 1'b1;
            w_next_dcnt    = r_dcnt - 3'd1;
            w_next_state   = (r_dcnt == 3'd1) ? S_RUN : S_STALL;
        end else if (w_lu) begin
            // A jump sitting in ID here is held and only counted once it issues.
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
            id_ex_flush    = 1'b1;
            w_stall_inc    = 1'b1;
            if (STALL_CYCLES > 1) begin
                w_next_dcnt  = LP_RELOAD;
                w_next_state = S_STALL;
            end
        end else if (id_jump) begin
            if_id_flush = 1'b1;
            w_flush_inc = 1'b1;
        end
    end

    // State, saved pre-freeze state, down-counter and saturating event counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_RUN;
            r_ret_state <= S_RUN;
            r_dcnt      <= 3'd0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state     <= w_next_state;
            r_ret_state <= w_next_ret;
            r_dcnt      <= w_next_dcnt;
            if (w_stall_inc && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + LP_CNT_ONE;
            end
            if (w_flush_inc && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + LP_CNT_ONE;
            end
        end
    end

    assign state     = r_state;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] id_rs = '0, id_rt = '0, ex_rs = '0, ex_rt = '0;
    logic [4:0] ex_wreg = '0, mem_wreg = '0, wb_wreg = '0;
    logic       id_uses_rt = 1'b0, id_jump = 1'b0, ex_mem_read = 1'b0;
    logic       mem_reg_write = 1'b0, mem_branch_taken = 1'b0;
    logic       wb_reg_write = 1'b0, mem_busy = 1'b0;

    always #5 clk = ~clk;

    logic       a_pc, a_ifid, a_pipe, a_fl1, a_fl2, a_fl3;
    logic [1:0] a_fa, a_fb, a_st;
    logic [3:0] a_sc, a_fc;
    logic       b_pc, b_ifid, b_pipe, b_fl1, b_fl2, b_fl3;
    logic [1:0] b_fa, b_fb, b_st;
    logic [15:0] b_sc, b_fc;

    pipeline_hazard_ctrl #(.STALL_CYCLES(1), .CNT_WIDTH(4)) dut_a (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .id_jump(id_jump), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_mem_read(ex_mem_read),
        .ex_wreg(ex_wreg), .mem_reg_write(mem_reg_write), .mem_wreg(mem_wreg),
        .mem_branch_taken(mem_branch_taken), .wb_reg_write(wb_reg_write), .wb_wreg(wb_wreg),
        .mem_busy(mem_busy), .pc_write_en(a_pc), .if_id_write_en(a_ifid), .pipe_en(a_pipe),
        .if_id_flush(a_fl1), .id_ex_flush(a_fl2), .ex_mem_flush(a_fl3), .fwd_a(a_fa),
        .fwd_b(a_fb), .state(a_st), .stall_cnt(a_sc), .flush_cnt(a_fc));

    pipeline_hazard_ctrl #(.STALL_CYCLES(3), .CNT_WIDTH(16)) dut_b (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .id_jump(id_jump), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_mem_read(ex_mem_read),
        .ex_wreg(ex_wreg), .mem_reg_write(mem_reg_write), .mem_wreg(mem_wreg),
        .mem_branch_taken(mem_branch_taken), .wb_reg_write(wb_reg_write), .wb_wreg(wb_wreg),
        .mem_busy(mem_busy), .pc_write_en(b_pc), .if_id_write_en(b_ifid), .pipe_en(b_pipe),
        .if_id_flush(b_fl1), .id_ex_flush(b_fl2), .ex_mem_flush(b_fl3), .fwd_a(b_fa),
        .fwd_b(b_fb), .state(b_st), .stall_cnt(b_sc), .flush_cnt(b_fc));

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: bubbles still owed, frozen flag, event counts, per instance.
    int  sc_cfg[2]  = '{1, 3};
    int  max_cnt[2] = '{15, 65535};
    int  m_bl[2], m_frz[2], m_scnt[2], m_fcnt[2];
    bit  m_valid = 0;

    function automatic bit load_use();
        return ex_mem_read && ex_wreg != 0 &&
               (ex_wreg == id_rs || (id_uses_rt && ex_wreg == id_rt));
    endfunction

    function automatic int fsel(input logic [4:0] r);
        if (reset) return 0;
        if (mem_reg_write && mem_wreg != 0 && mem_wreg == r) return 2;
        if (wb_reg_write && wb_wreg != 0 && wb_wreg == r) return 1;
        return 0;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                m_bl[k] = 0; m_frz[k] = 0; m_scnt[k] = 0; m_fcnt[k] = 0;
            end else if (m_valid) begin
                if (mem_busy) begin
                    m_frz[k] = 1;
                end else begin
                    m_frz[k] = 0;
                    if (mem_branch_taken) begin
                        m_bl[k] = 0;
                        if (m_fcnt[k] < max_cnt[k]) m_fcnt[k]++;
                    end else if (m_bl[k] > 0) begin
                        m_bl[k]--;
                        if (m_scnt[k] < max_cnt[k]) m_scnt[k]++;
                    end else if (load_use()) begin
                        m_bl[k] = sc_cfg[k] - 1;
                        if (m_scnt[k] < max_cnt[k]) m_scnt[k]++;
                    end else if (id_jump) begin
                        if (m_fcnt[k] < max_cnt[k]) m_fcnt[k]++;
                    end
                end
            end
        end
        if (reset) m_valid = 1;
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            for (int k = 0; k < 2; k++) begin
                int e_pc, e_ifid, e_pipe, e_f1, e_f2, e_f3, e_st;
                int g_pc, g_ifid, g_pipe, g_f1, g_f2, g_f3, g_st, g_fa, g_fb, g_sc, g_fc;
                e_pc = 1; e_ifid = 1; e_pipe = 1; e_f1 = 0; e_f2 = 0; e_f3 = 0;
                if (!reset) begin
                    if (mem_busy) begin
                        e_pc = 0; e_ifid = 0; e_pipe = 0;
                    end else if (mem_branch_taken) begin
                        e_f1 = 1; e_f2 = 1; e_f3 = 1;
                    end else if (m_bl[k] > 0 || load_use()) begin
                        e_pc = 0; e_ifid = 0; e_f2 = 1;
                    end else if (id_jump) begin
                        e_f1 = 1;
                    end
                end
                e_st = m_frz[k] ? 2 : (m_bl[k] > 0 ? 1 : 0);
                if (k == 0) begin
                    g_pc = a_pc; g_ifid = a_ifid; g_pipe = a_pipe; g_f1 = a_fl1; g_f2 = a_fl2;
                    g_f3 = a_fl3; g_st = a_st; g_fa = a_fa; g_fb = a_fb; g_sc = a_sc; g_fc = a_fc;
                end else begin
                    g_pc = b_pc; g_ifid = b_ifid; g_pipe = b_pipe; g_f1 = b_fl1; g_f2 = b_fl2;
                    g_f3 = b_fl3; g_st = b_st; g_fa = b_fa; g_fb = b_fb; g_sc = b_sc; g_fc = b_fc;
                end
                chk($sformatf("m%0d pc_write_en", k), g_pc, e_pc);
                chk($sformatf("m%0d if_id_write_en", k), g_ifid, e_ifid);
                chk($sformatf("m%0d pipe_en", k), g_pipe, e_pipe);
                chk($sformatf("m%0d if_id_flush", k), g_f1, e_f1);
                chk($sformatf("m%0d id_ex_flush", k), g_f2, e_f2);
                chk($sformatf("m%0d ex_mem_flush", k), g_f3, e_f3);
                chk($sformatf("m%0d state", k), g_st, e_st);
                chk($sformatf("m%0d fwd_a", k), g_fa, fsel(ex_rs));
                chk($sformatf("m%0d fwd_b", k), g_fb, fsel(ex_rt));
                chk($sformatf("m%0d stall_cnt", k), g_sc, m_scnt[k]);
                chk($sformatf("m%0d flush_cnt", k), g_fc, m_fcnt[k]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs = 0; id_rt = 0; ex_rs = 0; ex_rt = 0; ex_wreg = 0; mem_wreg = 0; wb_wreg = 0;
        id_uses_rt = 0; id_jump = 0; ex_mem_read = 0; mem_reg_write = 0;
        mem_branch_taken = 0; wb_reg_write = 0; mem_busy = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1; tick(); tick(); reset = 0;
    endtask

    task automatic set_lu();
        ex_mem_read = 1; ex_wreg = 5'd8; id_rs = 5'd8;
    endtask

    initial begin
        do_reset();
        @(negedge clk);
        chk("reset state", b_st, 0);
        chk("reset stall_cnt", b_sc, 0);
        chk("reset pc_write_en", a_pc, 1);

        // Forwarding priority and $0
        mem_reg_write = 1; mem_wreg = 8; wb_reg_write = 1; wb_wreg = 8; ex_rs = 8;
        @(negedge clk); chk("fwd exmem prio", a_fa, 2);
        tick(); mem_wreg = 0;
        @(negedge clk); chk("fwd wb", a_fa, 1);
        tick(); wb_reg_write = 0; ex_rs = 0; mem_reg_write = 1; mem_wreg = 0; ex_rt = 0;
        @(negedge clk); chk("fwd r0", a_fb, 0);
        tick(); wb_reg_write = 1; wb_wreg = 5; ex_rt = 5;
        @(negedge clk); chk("fwd_b wb", a_fb, 1);
        tick(); clear_inputs();

        // Single-bubble load-use
        set_lu();
        @(negedge clk);
        chk("lu pc_write_en", a_pc, 0);
        chk("lu id_ex_flush", a_fl2, 1);
        tick(); ex_mem_read = 0;
        @(negedge clk);
        chk("lu released", a_pc, 1);
        chk("lu stall_cnt", a_sc, 1);
        tick(); tick(); tick();
        @(negedge clk); chk("lu3 stall_cnt", b_sc, 3);

        // Branch during a 3-cycle stall
        do_reset();
        set_lu(); tick(); ex_mem_read = 0; tick();
        mem_branch_taken = 1;
        @(negedge clk);
        chk("br flushes", {b_fl1, b_fl2, b_fl3}, 7);
        chk("br pc_write_en", b_pc, 1);
        tick(); mem_branch_taken = 0;
        @(negedge clk);
        chk("br state", b_st, 0);
        chk("br stall_cnt", b_sc, 2);
        chk("br flush_cnt", b_fc, 1);

        // Freeze in the middle of a stall
        do_reset();
        set_lu(); tick(); ex_mem_read = 0; mem_busy = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("frz enables", {b_pc, b_ifid, b_pipe}, 0);
            tick();
        end
        mem_busy = 0;
        @(negedge clk);
        chk("frz exit state", b_st, 2);
        chk("frz exit bubble", b_fl2, 1);
        tick();
        @(negedge clk); chk("frz resumed", b_st, 1);
        tick();
        @(negedge clk);
        chk("frz done state", b_st, 0);
        chk("frz stall_cnt", b_sc, 3);

        // Branch held through a freeze
        do_reset();
        mem_busy = 1; mem_branch_taken = 1; tick(); tick(); mem_busy = 0;
        @(negedge clk); chk("held br flush", b_fl3, 1);
        tick(); clear_inputs();

        // Saturating jump counter, then reset mid-stall
        do_reset();
        id_jump = 1;
        repeat (20) tick();
        id_jump = 0;
        @(negedge clk);
        chk("jump sat cnt4", a_fc, 15);
        chk("jump cnt16", b_fc, 20);
        set_lu(); tick(); ex_mem_read = 0;
        @(negedge clk); chk("mid stall", b_st, 1);
        reset = 1; tick(); reset = 0;
        @(negedge clk);
        chk("rst state", b_st, 0);
        chk("rst stall_cnt", b_sc, 0);
        chk("rst flush_cnt", b_fc, 0);

        // Mixed traffic checked by the model every cycle
        for (int i = 0; i < 400; i++) begin
            id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
            ex_rs = 5'($urandom_range(0, 3)); ex_rt = 5'($urandom_range(0, 3));
            ex_wreg = 5'($urandom_range(0, 3)); mem_wreg = 5'($urandom_range(0, 3));
            wb_wreg = 5'($urandom_range(0, 3));
            id_uses_rt = 1'($urandom_range(0, 1)); mem_reg_write = 1'($urandom_range(0, 1));
            wb_reg_write = 1'($urandom_range(0, 1));
            ex_mem_read = ($urandom_range(0, 2) == 0);
            id_jump = ($urandom_range(0, 5) == 0);
            mem_branch_taken = ($urandom_range(0, 9) == 0);
            mem_busy = ($urandom_range(0, 7) == 0);
            tick();
        end
        clear_inputs();
        tick();
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
